// File: rtl/brief_frame_matcher.sv
// Brute-force BRIEF descriptor matcher: each current-frame descriptor is compared against every
// descriptor stored from the previous frame, and the minimum Hamming distance match is reported.
module brief_frame_matcher #(
  parameter int MAX_DESC     = 1024,
  parameter int DESC_BITS    = 256,
  parameter int COORD_W      = 11,
  parameter int MATCH_THRESH = 64,
  parameter int S_AXIS_WIDTH = 280,
  parameter int M_AXIS_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [M_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int AW     = $clog2(MAX_DESC);
  localparam int CNT_W  = $clog2(MAX_DESC + 1);
  localparam int DIST_W = $clog2(DESC_BITS + 1);
  localparam int ENT_W  = 2 * COORD_W + DESC_BITS;
  localparam int MCNT_W = 11;

  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_DESC);
  localparam logic [DIST_W-1:0] THRESH  = DIST_W'(MATCH_THRESH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;
  localparam logic [1:0] ST_EOF    = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    bank_sel_q, bank_sel_d;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]        prev_cnt_q, prev_cnt_d;
  logic [MCNT_W-1:0]       match_cnt_q, match_cnt_d;
  logic [CNT_W:0]          cyc_q, cyc_d;
  logic [M_AXIS_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;

  logic                    ram_vld_q, xor_vld_q, dist_vld_q;
  logic [ENT_W-1:0]        rd_q;
  logic [DESC_BITS-1:0]    xor_q;
  logic [COORD_W-1:0]      xor_x_q, xor_y_q;
  logic [DIST_W-1:0]       dist_q;
  logic [COORD_W-1:0]      dist_x_q, dist_y_q;
  logic [DIST_W-1:0]       best_q, best_d;
  logic [COORD_W-1:0]      best_x_q, best_x_d, best_y_q, best_y_d;
  logic [COORD_W-1:0]      cur_x_q, cur_y_q;
  logic [DESC_BITS-1:0]    cur_desc_q;

  // Both ping-pong banks share one array; the bank select is the top address bit.
  logic [ENT_W-1:0] mem_q [2*MAX_DESC];

  logic          data_acc, eof_acc, rd_issue, search_done, mem_we;
  logic [AW:0]   wr_addr, rd_addr;
  logic          unused_tdata;

  assign unused_tdata = &{1'b0, s_axis_tdata[S_AXIS_WIDTH-1:ENT_W]};

  assign s_axis_tready = (state_q == ST_IDLE);
  assign data_acc      = s_axis_tvalid && s_axis_tready && !s_axis_tlast;
  assign eof_acc       = s_axis_tvalid && s_axis_tready && s_axis_tlast;
  assign mem_we        = data_acc && (wr_cnt_q < MAX_CNT);
  assign wr_addr       = {bank_sel_q, wr_cnt_q[AW-1:0]};
  assign rd_addr       = {~bank_sel_q, cyc_q[AW-1:0]};
  assign rd_issue      = (state_q == ST_SEARCH) && (cyc_q < {1'b0, prev_cnt_q});
  // Last distance leaves the two-stage XOR/popcount pipe prev_cnt+2 cycles after the first read.
  assign search_done   = (state_q == ST_SEARCH) &&
                         (cyc_q == ({1'b0, prev_cnt_q} + (CNT_W+1)'(2)));

  function automatic logic [DIST_W-1:0] popcount(input logic [DESC_BITS-1:0] v);
    logic [DIST_W-1:0] c;
    c = '0;
    for (int i = 0; i < DESC_BITS; i++) c = c + DIST_W'(v[i]);
    return c;
  endfunction

  // NOTE: descriptor storage carries no reset; every entry read is written earlier in the frame.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr] <= s_axis_tdata[ENT_W-1:0];
    rd_q <= mem_q[rd_addr];
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    best_d   = best_q;
    best_x_d = best_x_q;
    best_y_d = best_y_q;
    // Strict compare keeps the lowest index on a tie.
    if (dist_vld_q && (dist_q < best_q)) begin
      best_d   = dist_q;
      best_x_d = dist_x_q;
      best_y_d = dist_y_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    wr_cnt_d    = wr_cnt_q;
    prev_cnt_d  = prev_cnt_q;
    match_cnt_d = match_cnt_q;
    cyc_d       = cyc_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    case (state_q)
      ST_IDLE: begin
        if (data_acc) begin
          if (wr_cnt_q < MAX_CNT) wr_cnt_d = wr_cnt_q + 1'b1;
          cyc_d = '0;
          if (prev_cnt_q != '0) state_d = ST_SEARCH;
        end else if (eof_acc) begin
          bank_sel_d = ~bank_sel_q;
          prev_cnt_d = wr_cnt_q;
          wr_cnt_d   = '0;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b1;
          m_tdata_d  = M_AXIS_WIDTH'(match_cnt_q);
          state_d    = ST_EOF;
        end
      end
      ST_SEARCH: begin
        cyc_d = cyc_q + 1'b1;
        if (search_done) begin
          if (best_d < THRESH) begin
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
            m_tvalid_d = 1'b1;
            m_tdata_d  = M_AXIS_WIDTH'({best_d, best_y_d, best_x_d, cur_y_q, cur_x_q});
            state_d    = ST_EMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EMIT, ST_EOF: begin
        if (m_axis_tready) begin
          if (state_q == ST_EOF) match_cnt_d = '0;
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
          m_tdata_d  = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bank_sel_q  <= 1'b0;
      wr_cnt_q    <= '0;
      prev_cnt_q  <= '0;
      match_cnt_q <= '0;
      cyc_q       <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      ram_vld_q   <= 1'b0;
      xor_vld_q   <= 1'b0;
      dist_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      wr_cnt_q    <= wr_cnt_d;
      prev_cnt_q  <= prev_cnt_d;
      match_cnt_q <= match_cnt_d;
      cyc_q       <= cyc_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      ram_vld_q   <= rd_issue;
      xor_vld_q   <= ram_vld_q;
      dist_vld_q  <= xor_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    xor_q    <= rd_q[DESC_BITS-1:0] ^ cur_desc_q;
    xor_x_q  <= rd_q[DESC_BITS +: COORD_W];
    xor_y_q  <= rd_q[DESC_BITS+COORD_W +: COORD_W];
    dist_q   <= popcount(xor_q);
    dist_x_q <= xor_x_q;
    dist_y_q <= xor_y_q;
    if (data_acc) begin
      cur_desc_q <= s_axis_tdata[DESC_BITS-1:0];
      cur_x_q    <= s_axis_tdata[DESC_BITS +: COORD_W];
      cur_y_q    <= s_axis_tdata[DESC_BITS+COORD_W +: COORD_W];
      best_q     <= '1;
    end else if (state_q == ST_SEARCH) begin
      best_q   <= best_d;
      best_x_q <= best_x_d;
      best_y_q <= best_y_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;

endmodule
